// File: rtl/enigma_step_controller.sv
// rtl/enigma_step_controller.sv - key sequencing and rotor stepping for the Enigma datapath
//
// Ports:
//   clk, rst                     clock; asynchronous active-low reset
//   load, load_r1/2/3            load initial rotor positions (IDLE only)
//   key_valid, key_data          key handshake input, key_ready back-pressure
//   dp_in, dp_out                letter to / result from the combinational datapath
//   r1_pos, r2_pos, r3_pos       rotor positions driven into the datapath
//   out_valid, out_data          one-cycle strobe with the encrypted letter
//   err                          one-cycle strobe for any rejected request or bad dp_out
//   char_count                   characters completed, wraps at 2^CNT_W
module enigma_step_controller #(
  parameter int R1_NOTCH      = 16,
  parameter int R2_NOTCH      = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [5:0]       load_r1,
  input  logic [5:0]       load_r2,
  input  logic [5:0]       load_r3,
  input  logic             key_valid,
  input  logic [5:0]       key_data,
  output logic             key_ready,
  output logic [5:0]       dp_in,
  input  logic [5:0]       dp_out,
  output logic [5:0]       r1_pos,
  output logic [5:0]       r2_pos,
  output logic [5:0]       r3_pos,
  output logic             out_valid,
  output logic [5:0]       out_data,
  output logic             err,
  output logic [CNT_W-1:0] char_count
);

  typedef enum logic [1:0] {IDLE, STEP, SETTLE, CAPTURE} state_t;

  localparam logic [5:0] R1N         = 6'(R1_NOTCH);
  localparam logic [5:0] R2N         = 6'(R2_NOTCH);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] settle_cnt;
  logic       accept;
  logic       load_take;
  logic       load_bad;
  logic       err_next;

  function automatic logic [5:0] inc26(input logic [5:0] p);
    return (p == 6'd25) ? 6'd0 : p + 6'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    load_take  = 1'b0;
    err_next   = 1'b0;
    key_ready  = 1'b0;
    load_bad   = (load_r1 > 6'd25) || (load_r2 > 6'd25) || (load_r3 > 6'd25);
    case (state)
      IDLE: begin
        // key_ready is gated by rst so it reads 0 for the whole reset period
        key_ready = rst && !load;
        if (load) begin
          if (load_bad) err_next  = 1'b1;
          else          load_take = 1'b1;
        end else if (key_valid) begin
          if (key_data <= 6'd25) begin
            accept     = 1'b1;
            state_next = STEP;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      STEP:    state_next = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) state_next = CAPTURE;
      CAPTURE: begin
        state_next = IDLE;
        if (dp_out > 6'd25) err_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    // a load arriving while busy is refused and flagged
    if (load && (state != IDLE)) err_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_pos     <= 6'd0;
      r2_pos     <= 6'd0;
      r3_pos     <= 6'd0;
      dp_in      <= 6'd0;
      out_data   <= 6'd0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
      char_count <= '0;
      settle_cnt <= 4'd0;
    end else begin
      out_valid <= (state == CAPTURE);
      err       <= err_next;
      if (accept) dp_in <= key_data;
      if (load_take) begin
        r1_pos <= load_r1;
        r2_pos <= load_r2;
        r3_pos <= load_r3;
      end
      case (state)
        STEP: begin
          // all three decisions use the pre-step positions; r2 stepping on
          // its own notch is the double-step anomaly
          r1_pos <= inc26(r1_pos);
          if ((r1_pos == R1N) || (r2_pos == R2N)) r2_pos <= inc26(r2_pos);
          if (r2_pos == R2N) r3_pos <= inc26(r3_pos);
          settle_cnt <= 4'd0;
        end
        SETTLE:  settle_cnt <= settle_cnt + 4'd1;
        CAPTURE: begin
          out_data   <= dp_out;
          char_count <= char_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_step_controller.sv
// tb/tb_enigma_step_controller.sv - self-checking bench for enigma_step_controller
module tb_enigma_step_controller;

  localparam int SETTLE = 2;
  localparam int CW     = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load = 1'b0;
  logic [5:0]    load_r1 = '0, load_r2 = '0, load_r3 = '0;
  logic          key_valid = 1'b0;
  logic [5:0]    key_data = '0;
  logic          key_ready;
  logic [5:0]    dp_in, dp_out;
  logic [5:0]    r1_pos, r2_pos, r3_pos;
  logic          out_valid;
  logic [5:0]    out_data;
  logic          err;
  logic [CW-1:0] char_count;

  logic          force_en = 1'b0;
  logic [5:0]    force_val = '0;
  logic [7:0]    dp_sum;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_count = 0;

  typedef struct {
    logic [5:0] data;
    int         cyc;
    logic       err;
    int         cnt;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic       ld;
    logic [5:0] l1, l2, l3;
    logic       kv;
    logic [5:0] key;
    logic       fe;
    logic [5:0] fv;
    logic [5:0] e1, e2, e3;
    logic       eacc;
    logic       eerr;
  } vec_t;
  vec_t vt[15];

  enigma_step_controller #(
    .R1_NOTCH(16), .R2_NOTCH(4), .SETTLE_CYCLES(SETTLE), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .load(load),
    .load_r1(load_r1), .load_r2(load_r2), .load_r3(load_r3),
    .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready),
    .dp_in(dp_in), .dp_out(dp_out),
    .r1_pos(r1_pos), .r2_pos(r2_pos), .r3_pos(r3_pos),
    .out_valid(out_valid), .out_data(out_data), .err(err),
    .char_count(char_count)
  );

  // stand-in datapath: simple sum cipher unless a value is forced
  assign dp_sum = 8'(dp_in) + 8'(r1_pos) + 8'(r2_pos) + 8'(r3_pos);
  assign dp_out = force_en ? force_val : 6'(dp_sum % 8'd26);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("out_data", out_data, e.data);
        check("out_latency_cycle", cyc, e.cyc);
        check("out_err", err, e.err);
        check("char_count", char_count, e.cnt);
      end
    end
  end

  task automatic push_expect(input logic [5:0] d, input logic e);
    sb_t s;
    exp_count++;
    s.data = d;
    s.cyc  = cyc + 1 + SETTLE + 2;
    s.err  = e;
    s.cnt  = exp_count;
    sb.push_back(s);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic apply(input vec_t v);
    int d;
    @(negedge clk);
    load = v.ld; load_r1 = v.l1; load_r2 = v.l2; load_r3 = v.l3;
    key_valid = v.kv; key_data = v.key;
    force_en = v.fe; force_val = v.fv;
    #1;
    check("key_ready_drive", key_ready, !v.ld);
    if (v.eacc) begin
      d = (int'(v.key) + int'(v.e1) + int'(v.e2) + int'(v.e3)) % 26;
      push_expect(v.fe ? v.fv : 6'(d), v.fe && (v.fv > 6'd25));
    end
    @(negedge clk);
    load = 1'b0; key_valid = 1'b0;
    #1;
    check("err_pulse", err, v.eerr);
    check("key_ready_after", key_ready, !v.eacc);
    @(negedge clk);
    #1;
    check("err_cleared", err, 0);
    check("r1_pos", r1_pos, v.e1);
    check("r2_pos", r2_pos, v.e2);
    check("r3_pos", r3_pos, v.e3);
    drain();
    force_en = 1'b0;
  endtask

  initial begin
    //          ld    l1     l2     l3     kv    key    fe    fv     e1     e2     e3    acc   err
    vt[0]  = '{1'b0, 6'd0,  6'd0,  6'd0,  1'b1, 6'd0,  1'b0, 6'd0,  6'd1,  6'd0,  6'd0,  1'b1, 1'b0};
    vt[1]  = '{1'b1, 6'd16, 6'd3,  6'd0,  1'b0, 6'd0,  1'b0, 6'd0,  6'd16, 6'd3,  6'd0,  1'b0, 1'b0};
    vt[2]  = '{1'b0, 6'd0,  6'd0,  6'd0,  1'b1, 6'd7,  1'b0, 6'd0,  6'd17, 6'd4,  6'd0,  1'b1, 1'b0};
    vt[3]  = '{1'b0, 6'd0,  6'd0,  6'd0,  1'b1, 6'd12, 1'b0, 6'd0,  6'd18, 6'd5,  6'd1,  1'b1, 1'b0};
    vt[4]  = '{1'b0, 6'd0,  6'd0,  6'd0,  1'b1, 6'd25, 1'b0, 6'd0,  6'd19, 6'd5,  6'd1,  1'b1, 1'b0};
    vt[5]  = '{1'b1, 6'd25, 6'd25, 6'd25, 1'b0, 6'd0,  1'b0, 6'd0,  6'd25, 6'd25, 6'd25, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 6'd0,  6'd0,  6'd0,  1'b1, 6'd3,  1'b0, 6'd0,  6'd0,  6'd25, 6'd25, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 6'd16, 6'd25, 6'd0,  1'b0, 6'd0,  1'b0, 6'd0,  6'd16, 6'd25, 6'd0,  1'b0, 1'b0};
    vt[8]  = '{1'b0, 6'd0,  6'd0,  6'd0,  1'b1, 6'd4,  1'b1, 6'd5,  6'd17, 6'd0,  6'd0,  1'b1, 1'b0};
    vt[9]  = '{1'b0, 6'd0,  6'd0,  6'd0,  1'b1, 6'd30, 1'b0, 6'd0,  6'd17, 6'd0,  6'd0,  1'b0, 1'b1};
    vt[10] = '{1'b1, 6'd0,  6'd26, 6'd0,  1'b0, 6'd0,  1'b0, 6'd0,  6'd17, 6'd0,  6'd0,  1'b0, 1'b1};
    vt[11] = '{1'b1, 6'd2,  6'd4,  6'd9,  1'b1, 6'd1,  1'b0, 6'd0,  6'd2,  6'd4,  6'd9,  1'b0, 1'b0};
    vt[12] = '{1'b0, 6'd0,  6'd0,  6'd0,  1'b1, 6'd10, 1'b1, 6'd40, 6'd3,  6'd5,  6'd10, 1'b1, 1'b0};
    vt[13] = '{1'b1, 6'd16, 6'd4,  6'd25, 1'b0, 6'd0,  1'b0, 6'd0,  6'd16, 6'd4,  6'd25, 1'b0, 1'b0};
    vt[14] = '{1'b0, 6'd0,  6'd0,  6'd0,  1'b1, 6'd2,  1'b0, 6'd0,  6'd17, 6'd5,  6'd0,  1'b1, 1'b0};

    // reset values
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_key_ready", key_ready, 0);
    check("rst_r1", r1_pos, 0);
    check("rst_r2", r2_pos, 0);
    check("rst_r3", r3_pos, 0);
    check("rst_dp_in", dp_in, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err", err, 0);
    check("rst_char_count", char_count, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("release_key_ready", key_ready, 1);

    foreach (vt[i]) apply(vt[i]);

    // load (with a stray key) during SETTLE: refused, output still on time
    @(negedge clk);
    key_valid = 1'b1; key_data = 6'd0;
    #1;
    push_expect(6'd23, 1'b0);  // 0 + 18 + 5 + 0
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    load = 1'b1; load_r1 = 6'd1; load_r2 = 6'd1; load_r3 = 6'd1;
    key_valid = 1'b1; key_data = 6'd9;
    @(negedge clk);
    load = 1'b0; key_valid = 1'b0;
    #1;
    check("busy_load_err", err, 1);
    check("busy_key_ready", key_ready, 0);
    @(negedge clk);
    #1;
    check("busy_load_err_clear", err, 0);
    check("busy_r1", r1_pos, 18);
    check("busy_r2", r2_pos, 5);
    check("busy_r3", r3_pos, 0);
    drain();

    // reset during SETTLE aborts the key
    @(negedge clk);
    key_valid = 1'b1; key_data = 6'd1;
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_r1", r1_pos, 0);
    check("abort_r2", r2_pos, 0);
    check("abort_r3", r3_pos, 0);
    check("abort_char_count", char_count, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_key_ready", key_ready, 0);
    sb.delete();
    exp_count = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_release_ready", key_ready, 1);
    repeat (8) @(negedge clk);

    // forced datapath result captured after reset
    apply('{1'b0, 6'd0, 6'd0, 6'd0, 1'b1, 6'd7, 1'b1, 6'd5, 6'd1, 6'd0, 6'd0, 1'b1, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
